// File: rtl/spi_slave.sv
// Mode-0 SPI responder: oversamples SCK/SSEL/MOSI on clk, captures one WIDTH-bit
// MOSI frame per SSEL-low window and returns a preloaded word MSB first on MISO.
module spi_slave #(
  parameter int WIDTH = 32,
  parameter int SYNC  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             SCK,
  input  logic             SSEL,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO,
  output logic             MISO_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t            state_q, state_d;
  logic [SYNC-1:0]   sck_sync_q, sck_sync_d;
  logic [SYNC-1:0]   ssel_sync_q, ssel_sync_d;
  logic [SYNC-1:0]   mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]  rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]  tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0]  rx_data_q, rx_data_d;
  logic              overrun_q, overrun_d;
  logic              miso_oe_q, miso_oe_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  // armed_q: SSEL has been seen high since reset/enable, so a fall is a real frame start.
  logic              armed_q, armed_d;
  logic              settled_q, settled_d;

  logic sck_rise, sck_fall, ssel_rise, ssel_fall;

  assign sck_rise  =  sck_sync_q[SYNC-2]  & ~sck_sync_q[SYNC-1];
  assign sck_fall  = ~sck_sync_q[SYNC-2]  &  sck_sync_q[SYNC-1];
  assign ssel_rise =  ssel_sync_q[SYNC-2] & ~ssel_sync_q[SYNC-1];
  assign ssel_fall = ~ssel_sync_q[SYNC-2] &  ssel_sync_q[SYNC-1];

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC-2:0], SCK};
    ssel_sync_d = {ssel_sync_q[SYNC-2:0], SSEL};
    mosi_sync_d = {mosi_sync_q[SYNC-2:0], MOSI};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    miso_oe_d   = miso_oe_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    settled_d   = 1'b1;
    armed_d     = armed_q | (settled_q & ssel_sync_q[0]);

    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      overrun_d = 1'b0;
      miso_oe_d = 1'b0;
      armed_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ssel_fall && armed_q) begin
            tx_shift_d = tx_data;
            rx_shift_d = '0;
            bit_cnt_d  = '0;
            overrun_d  = 1'b0;
            miso_oe_d  = 1'b1;
            state_d    = ACTIVE;
          end
        end
        ACTIVE, DONE: begin
          // SCK edge is applied before the frame is judged on a coincident SSEL rise.
          if (sck_rise) begin
            if (state_q == ACTIVE) begin
              // Oldest stage: MOSI has been stable since the preceding SCK fall.
              rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync_q[SYNC-1]};
              bit_cnt_d  = bit_cnt_q + 1'b1;
              if (bit_cnt_d == CW'(WIDTH)) state_d = DONE;
            end else begin
              overrun_d = 1'b1;
            end
          end
          if (sck_fall && state_q == ACTIVE && bit_cnt_q < CW'(WIDTH))
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
          if (ssel_rise) begin
            state_d   = IDLE;
            miso_oe_d = 1'b0;
            if (bit_cnt_d == CW'(WIDTH) && !overrun_d) begin
              rx_data_d  = rx_shift_d;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      ssel_sync_q <= '1;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      overrun_q   <= 1'b0;
      miso_oe_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
      settled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ssel_sync_q <= ssel_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      miso_oe_q   <= miso_oe_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
      settled_q   <= settled_d;
    end
  end

  assign MISO      = (state_q == ACTIVE) ? tx_shift_q[WIDTH-1] : 1'b0;
  assign MISO_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a mode-0 master task drives frames and pushes
// the expected outcome; a monitor pops it on each rx_valid / frame_err pulse.
module tb_spi_slave;

  localparam int WIDTH = 32;
  localparam int SYNC  = 3;
  localparam int HALF  = 8;
  localparam int GAP   = 16;

  logic             clk = 1'b0;
  logic             reset, en, SCK, SSEL, MOSI;
  logic [WIDTH-1:0] tx_data;
  logic             MISO, MISO_oe, rx_valid, frame_err, busy;
  logic [WIDTH-1:0] rx_data;

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] model_rx;
  int               checks = 0;
  int               errors = 0;

  spi_slave #(.WIDTH(WIDTH), .SYNC(SYNC)) dut (
    .clk(clk), .reset(reset), .en(en), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI),
    .tx_data(tx_data), .MISO(MISO), .MISO_oe(MISO_oe), .rx_data(rx_data),
    .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid === 1'b1 || frame_err === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, '0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.err});
        chk("rx_data", rx_data, e.data);
        $display("frame done: err=%0b rx_data=%h", frame_err, rx_data);
      end
    end
  end

  // abort_kind: 0 none, 1 async reset after bit abort_at, 2 en low after bit abort_at
  task automatic run_frame(input logic [WIDTH-1:0] mosi, input int nbits,
                           input logic [WIDTH-1:0] tx, input int abort_kind, input int abort_at);
    logic [WIDTH-1:0] got;
    got = '0;
    if (abort_kind == 0) begin
      if (nbits == WIDTH) model_rx = mosi;
      sb.push_back({(nbits != WIDTH), model_rx});
    end
    tx_data = tx;
    SSEL = 1'b0;
    clk_wait(HALF);
    chk("miso_oe_active", {31'd0, MISO_oe}, 32'd1);
    chk("busy_active", {31'd0, busy}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < WIDTH) ? mosi[WIDTH-1-i] : 1'b0;
      if (i == 5) tx_data = ~tx;
      clk_wait(HALF);
      SCK = 1'b1;
      if (i < WIDTH) got = {got[WIDTH-2:0], MISO};
      else chk("miso_overrun_bit", {31'd0, MISO}, 32'd0);
      clk_wait(HALF);
      SCK = 1'b0;
      if (i == abort_at && abort_kind == 1) begin
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_oe", {31'd0, MISO_oe}, 32'd0);
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        chk("rst_rx_data", rx_data, '0);
        model_rx = '0;
        clk_wait(3);
        reset = 1'b1;
      end
      if (i == abort_at && abort_kind == 2) begin
        en = 1'b0;
        clk_wait(2);
        chk("en_off_busy", {31'd0, busy}, 32'd0);
        chk("en_off_oe", {31'd0, MISO_oe}, 32'd0);
      end
    end
    clk_wait(HALF);
    SSEL = 1'b1;
    MOSI = 1'b0;
    if (abort_kind == 0 && nbits >= WIDTH) chk("miso_word", got, tx);
    for (int c = 0; c < SYNC + 2 && sb.size() != 0; c++) begin
      @(negedge clk);
      #1;
    end
    chk("sb_drained", sb.size(), '0);
    if (abort_kind == 2) en = 1'b1;
    clk_wait(GAP);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    $display("frame mosi=%h bits=%0d tx=%h abort=%0d miso=%h", mosi, nbits, tx, abort_kind, got);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b1; SCK = 1'b0; SSEL = 1'b1; MOSI = 1'b0; tx_data = '0;
    model_rx = '0;
    clk_wait(3);
    chk("reset_rx_data", rx_data, '0);
    chk("reset_outs", {27'd0, MISO, MISO_oe, rx_valid, frame_err, busy}, '0);
    reset = 1'b1;
    clk_wait(5);

    run_frame(32'hA5A5_1234, 32, 32'hDEAD_BEEF, 0, -1);
    run_frame(32'h0000_0001, 32, 32'hCAFE_F00D, 0, -1);
    run_frame(32'h8000_0000, 32, 32'h1234_5678, 0, -1);
    run_frame(32'h0F0F_0F0F, 20, 32'h5555_AAAA, 0, -1);
    run_frame(32'h3C3C_C3C3, 33, 32'h8765_4321, 0, -1);
    run_frame(32'hFFFF_0000, 32, 32'h0BAD_CAFE, 1, 10);
    run_frame(32'h1357_9BDF, 32, 32'hF00D_1234, 0, -1);
    run_frame(32'h2468_ACE0, 32, 32'h7777_8888, 2, 10);
    run_frame(32'h9ABC_DEF0, 32, 32'hA1B2_C3D4, 0, -1);

    chk("final_sb_empty", sb.size(), '0);
    chk("final_rx_data", rx_data, model_rx);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
